// File: rtl/wm_pkg.sv
// -----------------------------------------------------------------------------
// wm_pkg
// Shared definitions for the washing-machine cycle sequencer:
//   - DUR_W        : width of every duration field (units)
//   - wm_state_e   : 3-bit sequencer state, values fixed by the bus encoding
//   - wm_preset_t  : the four duration fields taken from the preset mux
//   - phase_dur    : duration belonging to a given phase
//   - next_phase   : first phase after a given state whose duration is nonzero
// -----------------------------------------------------------------------------
package wm_pkg;

    localparam int DUR_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_SPIN  = 3'd4,
        ST_DONE  = 3'd5
    } wm_state_e;

    typedef struct packed {
        logic [DUR_W-1:0] cloth;
        logic [DUR_W-1:0] wash;
        logic [DUR_W-1:0] rinse;
        logic [DUR_W-1:0] spin;
    } wm_preset_t;

    // Duration of a timed phase; zero for IDLE/DONE so a DONE entry
    // leaves the down-counter at zero.
    function automatic logic [DUR_W-1:0] phase_dur(input wm_state_e s,
                                                   input wm_preset_t p);
        logic [DUR_W-1:0] d;
        case (s)
            ST_FILL:  d = p.cloth;
            ST_WASH:  d = p.wash;
            ST_RINSE: d = p.rinse;
            ST_SPIN:  d = p.spin;
            default:  d = '0;
        endcase
        return d;
    endfunction

    // Scan the later phases from last to first so the earliest nonzero
    // phase after 'cur' is the one left standing; DONE if none qualify.
    function automatic wm_state_e next_phase(input wm_state_e cur,
                                             input wm_preset_t p);
        wm_state_e nxt;
        nxt = ST_DONE;
        if (cur < ST_SPIN  && p.spin  != '0) nxt = ST_SPIN;
        if (cur < ST_RINSE && p.rinse != '0) nxt = ST_RINSE;
        if (cur < ST_WASH  && p.wash  != '0) nxt = ST_WASH;
        if (cur < ST_FILL  && p.cloth != '0) nxt = ST_FILL;
        return nxt;
    endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// -----------------------------------------------------------------------------
// wm_phase_timer
// Prescaler plus down-counter that times one phase in duration units.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : load count_o with load_val_i and restart the prescaler
//   load_val_i   : phase duration in units
//   enable_i     : prescaler/counter advance only while high (pause gate)
//   clear_i      : zero prescaler and counter (highest priority)
//   tick_o       : prescaler at TICK_DIV-1 while enabled (one unit elapsed)
//   last_o       : tick on the final unit (count == 1)
//   count_o      : units left, including the one in progress
// -----------------------------------------------------------------------------
module wm_phase_timer
    import wm_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [DUR_W-1:0] load_val_i,
    input  logic             enable_i,
    input  logic             clear_i,
    output logic             tick_o,
    output logic             last_o,
    output logic [DUR_W-1:0] count_o
);

    // A one-bit prescaler keeps TICK_DIV=1 legal; it then ticks every cycle.
    localparam int              PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;

    assign tick_o  = enable_i && (pre_q == PRE_MAX);
    assign last_o  = tick_o && (cnt_q == DUR_W'(1));
    assign count_o = cnt_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            pre_d = '0;
            cnt_d = '0;
        end else if (load_i) begin
            pre_d = '0;
            cnt_d = load_val_i;
        end else if (enable_i) begin
            if (tick_o) begin
                pre_d = '0;
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wm_cycle_controller.sv
// -----------------------------------------------------------------------------
// wm_cycle_controller
// Washing-machine cycle sequencer: latches the selected preset on start and
// runs FILL -> WASH -> RINSE -> SPIN -> DONE, skipping zero-length phases.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   start                            : begin a cycle (sampled in IDLE only)
//   abort                            : return to IDLE from any state
//   pause                            : freeze the running phase (WM_PAUSE_EN)
//   cloth, wash_time, rinse_time,
//   spin_time                        : preset durations in units
//   phase                            : current state encoding
//   remaining                        : units left in the current phase
//   fill_valve, motor_on, motor_fast : actuator controls
//   busy                             : any state but IDLE
//   done                             : one-cycle pulse in DONE
// Build option:
//   WM_PAUSE_EN : when defined, pause=1 in a timed phase holds the timer and
//                 forces all actuators off; when undefined pause is ignored.
// -----------------------------------------------------------------------------
module wm_cycle_controller
    import wm_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic [DUR_W-1:0] wash_time,
    input  logic [DUR_W-1:0] rinse_time,
    input  logic [DUR_W-1:0] spin_time,
    input  logic [DUR_W-1:0] cloth,
    output logic [2:0]       phase,
    output logic [DUR_W-1:0] remaining,
    output logic             fill_valve,
    output logic             motor_on,
    output logic             motor_fast,
    output logic             busy,
    output logic             done
);

    wm_state_e  state_q, state_d;
    wm_preset_t preset_q, preset_in;
    logic       latch_en;

    logic       fill_valve_q, motor_on_q, motor_fast_q, busy_q, done_q;

    logic             phase_active;
    logic             hold;
    logic             tmr_load, tmr_clear, tmr_last;
    logic [DUR_W-1:0] tmr_load_val, tmr_count;
    logic             unused_tick;

    assign preset_in    = '{cloth: cloth, wash: wash_time, rinse: rinse_time, spin: spin_time};
    assign phase_active = state_q inside {ST_FILL, ST_WASH, ST_RINSE, ST_SPIN};

`ifdef WM_PAUSE_EN
    assign hold = phase_active && pause;
`else
    logic unused_pause;
    assign hold         = 1'b0;
    assign unused_pause = pause;
`endif

    wm_phase_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .enable_i   (phase_active && !hold),
        .clear_i    (tmr_clear),
        .tick_o     (unused_tick),
        .last_o     (tmr_last),
        .count_o    (tmr_count)
    );

    // Next state and timer control. Phase entry always reloads the timer,
    // including entry to DONE, which loads zero.
    always_comb begin
        state_d      = state_q;
        latch_en     = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_clear    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // The preset is consumed straight from the mux on the
                    // latching edge; preset_q holds it from then on.
                    latch_en     = 1'b1;
                    state_d      = next_phase(ST_IDLE, preset_in);
                    tmr_load     = 1'b1;
                    tmr_load_val = phase_dur(state_d, preset_in);
                end
            end
            ST_FILL, ST_WASH, ST_RINSE, ST_SPIN: begin
                if (tmr_last) begin
                    state_d      = next_phase(state_q, preset_q);
                    tmr_load     = 1'b1;
                    tmr_load_val = phase_dur(state_d, preset_q);
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                tmr_clear = 1'b1;
            end
            default: begin
                state_d   = ST_IDLE;
                tmr_clear = 1'b1;
            end
        endcase

        // Abort overrides start and any tick; latched preset is left intact.
        if (abort) begin
            state_d   = ST_IDLE;
            latch_en  = 1'b0;
            tmr_load  = 1'b0;
            tmr_clear = 1'b1;
        end
    end

    // State, preset latch and registered output decode of the next state.
    // A held phase registers its actuators off for every frozen cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            // NOTE: the preset latch is reset too, so nothing downstream ever sees X.
            preset_q     <= '0;
            fill_valve_q <= 1'b0;
            motor_on_q   <= 1'b0;
            motor_fast_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            if (latch_en) preset_q <= preset_in;
            fill_valve_q <= (state_d == ST_FILL) && !hold;
            motor_on_q   <= (state_d inside {ST_WASH, ST_RINSE, ST_SPIN}) && !hold;
            motor_fast_q <= (state_d == ST_SPIN) && !hold;
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);
        end
    end

    assign phase      = state_q;
    assign remaining  = phase_active ? tmr_count : '0;
    assign fill_valve = fill_valve_q;
    assign motor_on   = motor_on_q;
    assign motor_fast = motor_fast_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_wm_cycle_controller.sv
// -----------------------------------------------------------------------------
// tb_wm_cycle_controller
// Self-checking bench: a schedule-queue model expands each started cycle into
// its per-cycle expected outputs; every falling edge compares the DUT with it.
// Directed scenarios add literal expectations on phase lengths and pulses.
// -----------------------------------------------------------------------------
module tb_wm_cycle_controller;

    localparam int TD = 4;
`ifdef WM_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] phase;
        logic [4:0] rem;
        logic       fill;
        logic       motor;
        logic       fast;
        logic       busy;
        logic       done;
    } exp_t;

    localparam exp_t IDLE_E = '0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, pause = 1'b0;
    logic [4:0] cloth = '0, wash_t = '0, rinse_t = '0, spin_t = '0;
    logic [2:0] phase;
    logic [4:0] remaining;
    logic       fill_valve, motor_on, motor_fast, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    // Statistics over DUT outputs, sampled on falling edges.
    int cnt_phase [8];
    int cnt_busy, cnt_done, cnt_fast, cnt_wash_off;

    exp_t cur = IDLE_E;
    exp_t sched[$];
    exp_t mdl_e;

    always #5 clk = ~clk;

    wm_cycle_controller #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pause      (pause),
        .wash_time  (wash_t),
        .rinse_time (rinse_t),
        .spin_time  (spin_t),
        .cloth      (cloth),
        .phase      (phase),
        .remaining  (remaining),
        .fill_valve (fill_valve),
        .motor_on   (motor_on),
        .motor_fast (motor_fast),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: a started cycle becomes the full list of the cycles it
    // will show; pause repeats the current entry with actuators off.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sched.delete();
            cur = IDLE_E;
        end else if (abort) begin
            sched.delete();
            cur = IDLE_E;
        end else if (cur.phase == 3'd0) begin
            if (start) begin
                int dur [5];
                dur[1] = int'(cloth);
                dur[2] = int'(wash_t);
                dur[3] = int'(rinse_t);
                dur[4] = int'(spin_t);
                for (int p = 1; p <= 4; p++) begin
                    for (int c = 0; c < dur[p] * TD; c++) begin
                        mdl_e       = '0;
                        mdl_e.phase = 3'(p);
                        mdl_e.rem   = 5'(dur[p] - c / TD);
                        mdl_e.fill  = (p == 1);
                        mdl_e.motor = (p >= 2);
                        mdl_e.fast  = (p == 4);
                        mdl_e.busy  = 1'b1;
                        sched.push_back(mdl_e);
                    end
                end
                mdl_e       = '0;
                mdl_e.phase = 3'd5;
                mdl_e.busy  = 1'b1;
                mdl_e.done  = 1'b1;
                sched.push_back(mdl_e);
                cur = sched.pop_front();
            end
        end else if (PAUSE_EN && pause && cur.phase >= 3'd1 && cur.phase <= 3'd4) begin
            cur.fill  = 1'b0;
            cur.motor = 1'b0;
            cur.fast  = 1'b0;
        end else if (sched.size() > 0) begin
            cur = sched.pop_front();
        end else begin
            cur = IDLE_E;
        end
    end

    // The one per-cycle compare process, plus output statistics.
    always @(negedge clk) begin
        check("cycle", 32'({phase, remaining, fill_valve, motor_on, motor_fast, busy, done}),
              32'(cur));
        cnt_phase[phase] += 1;
        if (busy) cnt_busy += 1;
        if (done) cnt_done += 1;
        if (motor_fast) cnt_fast += 1;
        if (phase == 3'd2 && !motor_on) cnt_wash_off += 1;
    end

    // Inputs change one time unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats();
        foreach (cnt_phase[i]) cnt_phase[i] = 0;
        cnt_busy     = 0;
        cnt_done     = 0;
        cnt_fast     = 0;
        cnt_wash_off = 0;
    endtask

    task automatic set_preset(input int c, input int w, input int r, input int s);
        cloth   = 5'(c);
        wash_t  = 5'(w);
        rinse_t = 5'(r);
        spin_t  = 5'(s);
    endtask

    initial begin
        bit found;
        clear_stats();

        // Reset values
        repeat (3) step();
        check("reset_outputs", 32'({phase, remaining, fill_valve, motor_on, motor_fast, busy, done}), 32'd0);
        rst = 1'b0;
        repeat (2) step();

        // Full cycle: cloth=2 wash=3 rinse=0 spin=1
        clear_stats();
        set_preset(2, 3, 0, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        set_preset(9, 9, 9, 9);   // must be ignored after latching
        check("start_busy_latency", 32'(busy), 32'd1);
        check("start_first_phase", 32'(phase), 32'd1);
        check("start_first_remaining", 32'(remaining), 32'd2);
        repeat (30) step();
        check("full_fill_cycles", 32'(cnt_phase[1]), 32'd8);
        check("full_wash_cycles", 32'(cnt_phase[2]), 32'd12);
        check("full_rinse_cycles", 32'(cnt_phase[3]), 32'd0);
        check("full_spin_cycles", 32'(cnt_phase[4]), 32'd4);
        check("full_fast_cycles", 32'(cnt_fast), 32'd4);
        check("full_done_pulses", 32'(cnt_done), 32'd1);
        check("full_busy_cycles", 32'(cnt_busy), 32'd25);

        // All durations zero: straight to DONE
        clear_stats();
        set_preset(0, 0, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("zero_phase_done", 32'(phase), 32'd5);
        check("zero_done_pulse", 32'(done), 32'd1);
        step();
        check("zero_back_idle", 32'(phase), 32'd0);
        repeat (3) step();
        check("zero_busy_cycles", 32'(cnt_busy), 32'd1);

        // Abort during RINSE with remaining=2
        clear_stats();
        set_preset(0, 0, 3, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (phase == 3'd3 && remaining == 5'd2) found = 1'b1;
            else step();
        end
        check("abort_reached_rinse_rem2", 32'(found), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_phase_idle", 32'(phase), 32'd0);
        check("abort_motor_off", 32'(motor_on), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        repeat (5) step();
        check("abort_done_count", 32'(cnt_done), 32'd0);

        // start and abort together in IDLE
        set_preset(1, 1, 1, 1);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 32'(phase), 32'd0);
        check("start_abort_busy", 32'(busy), 32'd0);

        // Pause mid-WASH for 5 cycles, wash=1
        clear_stats();
        set_preset(0, 1, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        pause = 1'b1;
        repeat (5) step();
        pause = 1'b0;
        repeat (12) step();
        check("pause_wash_cycles", 32'(cnt_phase[2]), PAUSE_EN ? 32'd9 : 32'd4);
        check("pause_motor_off_cycles", 32'(cnt_wash_off), PAUSE_EN ? 32'd5 : 32'd0);

        // Asynchronous reset mid-WASH
        clear_stats();
        set_preset(1, 5, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        check("rst_in_wash", 32'(phase), 32'd2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outputs", 32'({phase, remaining, fill_valve, motor_on, motor_fast, busy, done}), 32'd0);
        step();
        rst = 1'b0;
        repeat (3) step();
        check("rst_stays_idle", 32'(phase), 32'd0);
        check("rst_no_done", 32'(cnt_done), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            set_preset(($urandom_range(0, 9) < 3) ? 0 : int'($urandom_range(1, 4)),
                       ($urandom_range(0, 9) < 3) ? 0 : int'($urandom_range(1, 4)),
                       ($urandom_range(0, 9) < 3) ? 0 : int'($urandom_range(1, 4)),
                       ($urandom_range(0, 9) < 3) ? 0 : int'($urandom_range(1, 4)));
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 60) == 0);
            pause = ($urandom_range(0, 5) == 0);
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
